// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg
// Shared definitions for the AHB-to-APB bridge:
//   - AHB HTRANS and HRESP encodings
//   - bridge FSM state enum
//   - clog2 helper for parameter-derived widths
// Optional feature macro used by the bridge: APB_TIMEOUT_EN.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAPT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } apb_state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// apb_slv_mux
// Combinational slave selection for the bridge.
// Ports:
//   idx        in   slave index latched by the bridge
//   prdata     in   flattened read data, slave i at [32i+31:32i]
//   pready     in   per-slave ready
//   pslverr    in   per-slave error
//   sel_rdata  out  read data of slave idx (0 when idx is unmapped)
//   sel_ready  out  pready of slave idx (0 when idx is unmapped)
//   sel_err    out  pslverr of slave idx (0 when idx is unmapped)
//   sel_onehot out  one-hot decode of idx (all zero when unmapped)
module apb_slv_mux #(
    parameter int NUM_SLV = 4,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic [32*NUM_SLV-1:0] prdata,
    input  logic [NUM_SLV-1:0]    pready,
    input  logic [NUM_SLV-1:0]    pslverr,
    output logic [31:0]           sel_rdata,
    output logic                  sel_ready,
    output logic                  sel_err,
    output logic [NUM_SLV-1:0]    sel_onehot
);

    always_comb begin
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_rdata     = prdata[32*i +: 32];
                sel_ready     = pready[i];
                sel_err       = pslverr[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge
// Replays single AHB transfers as APB3 transfers to NUM_SLV peripherals,
// with pready wait states, pslverr -> AHB ERROR, decode errors for
// unmapped slave slots and (with APB_TIMEOUT_EN defined) an ACCESS timeout.
// Ports:
//   hclk, hreset            clock, synchronous active-high reset
//   hsel, haddr, htrans,
//   hwrite, hsize, hwdata,
//   hready_in               AHB slave inputs (hsize is ignored)
//   hready_out, hresp,
//   hrdata                  AHB slave outputs (hrdata registered)
//   paddr, psel, penable,
//   pwrite, pwdata          APB master outputs
//   prdata, pready, pslverr APB slave responses, per slave
//   fsm_state               current bridge state, for observation
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int PADDR_W     = 16,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    input  logic                  hready_in,
    output logic                  hready_out,
    output logic [1:0]            hresp,
    output logic [31:0]           hrdata,
    output logic [PADDR_W-3:0]    paddr,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    input  logic [32*NUM_SLV-1:0] prdata,
    input  logic [NUM_SLV-1:0]    pready,
    input  logic [NUM_SLV-1:0]    pslverr,
    output apb_state_t            fsm_state
);

    localparam int IDX_CLOG = clog2(NUM_SLV);
    localparam int IDX_W    = (IDX_CLOG < 1) ? 1 : IDX_CLOG;

    apb_state_t        state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  haddr_idx;
    logic              idx_valid;
    logic              accept;
    logic              take;
    logic [31:0]       sel_rdata;
    logic              sel_ready;
    logic              sel_err;
    logic [NUM_SLV-1:0] sel_onehot;

    // Only NONSEQ/SEQ start a transfer; IDLE/BUSY get a zero-wait OKAY.
    assign accept = hsel && hready_in &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    // A new address phase can only be taken while this bridge is ready.
    assign take   = accept && hready_out;

    // A single-slave build has no index field; the slot is always 0.
    assign haddr_idx = (NUM_SLV == 1) ? '0 : haddr[SEL_LSB +: IDX_W];
    assign idx_valid = ({1'b0, idx} < (IDX_W+1)'(NUM_SLV));

    assign fsm_state = state;

    wire unused_bits = &{1'b0, hsize, haddr};

    apb_slv_mux #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_mux (
        .idx        (idx),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .sel_rdata  (sel_rdata),
        .sel_ready  (sel_ready),
        .sel_err    (sel_err),
        .sel_onehot (sel_onehot)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TO_CLOG = clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W   = (TO_CLOG < 8) ? 8 : ((TO_CLOG > 16) ? 16 : TO_CLOG);
    // The counter holds the number of ACCESS cycles already spent, so the
    // abort fires in the TIMEOUT_CYC-th ACCESS cycle.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYC;
`endif

    always_comb begin
        state_nx   = state;
        hready_out = 1'b0;
        hresp      = HRESP_OKAY;
        psel       = '0;
        penable    = 1'b0;
        case (state)
            ST_IDLE: begin
                hready_out = 1'b1;
                if (take) state_nx = ST_CAPT;
            end
            ST_CAPT: begin
                state_nx = idx_valid ? ST_SETUP : ST_ERR1;
            end
            ST_SETUP: begin
                psel     = sel_onehot;
                state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = sel_onehot;
                penable = 1'b1;
                if (sel_ready) begin
                    state_nx = sel_err ? ST_ERR1 : ST_DONE;
                end
`ifdef APB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_nx = ST_ERR1;
                end
`endif
            end
            ST_DONE: begin
                hready_out = 1'b1;
                state_nx   = take ? ST_CAPT : ST_IDLE;
            end
            ST_ERR1: begin
                hresp    = HRESP_ERROR;
                state_nx = ST_ERR2;
            end
            ST_ERR2: begin
                hready_out = 1'b1;
                hresp      = HRESP_ERROR;
                state_nx   = take ? ST_CAPT : ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            hrdata <= '0;
        end else begin
            state <= state_nx;
            // Address-phase fields are only reloaded in IDLE/DONE/ERR2, so
            // they stay stable from SETUP through the end of ACCESS.
            if (take) begin
                idx    <= haddr_idx;
                paddr  <= haddr[PADDR_W-1:2];
                pwrite <= hwrite;
            end
            if (state == ST_CAPT) begin
                pwdata <= hwdata;
            end
            if ((state == ST_ACCESS) && sel_ready && !sel_err && !pwrite) begin
                hrdata <= sel_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge
// Bench for ahb2apb_bridge with NUM_SLV=3 (slot 3 is unmapped) and
// TIMEOUT_CYC=4. Timeout scenario is built only with APB_TIMEOUT_EN.
module tb_ahb2apb_bridge;
  import ahb_apb_pkg::*;

  localparam int NUM_SLV = 3;
  localparam int PADDR_W = 16;
  localparam int TO_CYC  = 4;
  localparam int BUDGET  = 40;

  // clock / reset
  logic hclk = 1'b0;
  logic hreset = 1'b1;
  always #5 hclk = ~hclk;

  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [31:0]           hwdata;
  logic                  hready_in;
  logic                  hready_out;
  logic [1:0]            hresp;
  logic [31:0]           hrdata;
  logic [PADDR_W-3:0]    paddr;
  logic [NUM_SLV-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [32*NUM_SLV-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;
  apb_state_t            fsm_state;

  ahb2apb_bridge #(
    .NUM_SLV     (NUM_SLV),
    .PADDR_W     (PADDR_W),
    .SEL_LSB     (12),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hready_in  (hready_in),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .fsm_state  (fsm_state)
  );

  // APB slave model
  logic [31:0]        slv_rdata [NUM_SLV];
  int                 cfg_wait;
  logic               cfg_err;
  int                 acc_cnt;
  logic [NUM_SLV-1:0] noise_rdy;
  logic [NUM_SLV-1:0] noise_err;

  assign prdata = {slv_rdata[2], slv_rdata[1], slv_rdata[0]};

  always @(posedge hclk) begin
    if (penable) acc_cnt <= acc_cnt + 1;
    else         acc_cnt <= 0;
  end

  always @(negedge hclk) begin
    noise_rdy = NUM_SLV'($urandom);
    noise_err = NUM_SLV'($urandom);
  end

  // Selected slave answers after cfg_wait low ACCESS cycles; the others
  // toggle randomly and must be ignored by the bridge.
  always_comb begin
    pready  = '0;
    pslverr = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel[i]) begin
        pready[i]  = (acc_cnt >= cfg_wait);
        pslverr[i] = cfg_err;
      end else begin
        pready[i]  = noise_rdy[i];
        pslverr[i] = noise_err[i];
      end
    end
  end

  // scoreboard: {wait_cycles[7:0], psel_cycles[7:0], hresp[1:0], hrdata[31:0]}
  logic [49:0] exp_q[$];
  logic [31:0] model_rdata;
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge while the bridge is ready; drives one address phase,
  // follows the transfer to completion and compares against the scoreboard.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic serr);
    logic [1:0]  idx;
    logic        valid;
    logic        tmo;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int          e_wait;
    int          e_pc;
    logic [49:0] e;
    logic [NUM_SLV-1:0] e_psel;
    int          cyc;
    int          pc;
    logic [1:0]  last_resp;

    idx   = addr[13:12];
    valid = (idx < 2'(NUM_SLV));
    tmo   = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo   = valid && !serr && (waits >= TO_CYC);
`endif
    e_psel = valid ? NUM_SLV'(1 << idx) : '0;
    e_rdata = model_rdata;
    if (!valid) begin
      e_resp = HRESP_ERROR; e_wait = 2; e_pc = 0;
    end else if (tmo) begin
      e_resp = HRESP_ERROR; e_wait = TO_CYC + 3; e_pc = TO_CYC + 1;
    end else if (serr) begin
      e_resp = HRESP_ERROR; e_wait = waits + 4; e_pc = waits + 2;
    end else begin
      e_resp = HRESP_OKAY; e_wait = waits + 3; e_pc = waits + 2;
      if (!wr) e_rdata = slv_rdata[idx];
    end
    model_rdata = e_rdata;
    exp_q.push_back({8'(e_wait), 8'(e_pc), e_resp, e_rdata});

    // address phase
    cfg_wait = waits;
    cfg_err  = serr;
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = addr;
    hwrite = wr;
    hsize  = 3'b010;
    @(negedge hclk);
    // data phase
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = $urandom;
    hwdata = wdata;
    cyc = 0;
    pc  = 0;
    last_resp = HRESP_OKAY;
    while (!hready_out && cyc < BUDGET) begin
      cyc++;
      last_resp = hresp;
      if (psel != '0) begin
        pc++;
        check_eq("psel", psel, e_psel);
        check_eq("paddr", paddr, addr[PADDR_W-1:2]);
        check_eq("pwrite", pwrite, wr);
        check_eq("pwdata", pwdata, wdata);
        check_eq("penable", penable, (pc > 1));
      end
      @(negedge hclk);
    end
    if (cyc >= BUDGET) check_eq("hready_budget", cyc, 0);
    e = exp_q.pop_front();
    check_eq("wait_cycles", cyc, e[49:42]);
    check_eq("psel_cycles", pc, e[41:34]);
    check_eq("hresp", hresp, e[33:32]);
    check_eq("hrdata", hrdata, e[31:0]);
    if (e[33:32] == HRESP_ERROR) check_eq("err1_hresp", last_resp, HRESP_ERROR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          k;
    hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; hready_in = 1'b1;
    cfg_wait = 0; cfg_err = 1'b0; acc_cnt = 0; model_rdata = '0;
    slv_rdata[0] = 32'h0BAD_0000;
    slv_rdata[1] = 32'h1111_2222;
    slv_rdata[2] = 32'hCAFE_0001;

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check_eq("rst_hready", hready_out, 1'b1);
    check_eq("rst_hresp", hresp, 2'b00);
    check_eq("rst_hrdata", hrdata, 32'h0);
    check_eq("rst_psel", psel, 3'b000);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_pwrite", pwrite, 1'b0);
    check_eq("rst_paddr", paddr, 14'h0);
    check_eq("rst_pwdata", pwdata, 32'h0);
    check_eq("rst_state", fsm_state, ST_IDLE);
    hreset = 1'b0;
    @(negedge hclk);

    // directed cases, back to back
    run_xfer(1'b0, 32'h0000_2024, 32'h0, 0, 1'b0);           // read slave 2
    run_xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b0);   // write slave 0, 3 waits
    run_xfer(1'b0, 32'h0000_3000, 32'h0, 0, 1'b0);           // unmapped slot
    run_xfer(1'b0, 32'h0000_1008, 32'h0, 1, 1'b1);           // slave error

    // IDLE/BUSY and hsel=0 are ignored with zero-wait OKAY
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h0000_1000;
    @(negedge hclk);
    hsel = 1'b1; htrans = HTRANS_IDLE;
    @(negedge hclk);
    check_eq("idle_hready", hready_out, 1'b1);
    check_eq("idle_psel", psel, 3'b000);
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    @(negedge hclk);
    htrans = HTRANS_IDLE;
    check_eq("nosel_hready", hready_out, 1'b1);
    check_eq("nosel_hresp", hresp, HRESP_OKAY);

    // random transfers, high address bits random
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      k = $urandom_range(0, 3);
      a[13:12] = 2'(k);
      a[1:0] = 2'b00;
      if (k < NUM_SLV) slv_rdata[k] = $urandom;
      run_xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0));
    end

    // reset in the middle of ACCESS
    cfg_wait = 5; cfg_err = 1'b0;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h0000_1004; hwrite = 1'b0;
    @(negedge hclk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'h5555_AAAA;
    k = 0;
    while (!penable && k < BUDGET) begin
      k++;
      @(negedge hclk);
    end
    check_eq("rst_mid_reach_access", penable, 1'b1);
    hreset = 1'b1;
    @(negedge hclk);
    check_eq("rst_mid_psel", psel, 3'b000);
    check_eq("rst_mid_penable", penable, 1'b0);
    check_eq("rst_mid_hready", hready_out, 1'b1);
    check_eq("rst_mid_hresp", hresp, 2'b00);
    check_eq("rst_mid_hrdata", hrdata, 32'h0);
    check_eq("rst_mid_pwdata", pwdata, 32'h0);
    hreset = 1'b0;
    model_rdata = '0;

    run_xfer(1'b0, 32'h0000_0100, 32'h0, 0, 1'b0);

`ifdef APB_TIMEOUT_EN
    run_xfer(1'b0, 32'h0000_1000, 32'h0, 1000, 1'b0);
    run_xfer(1'b0, 32'h0000_2000, 32'h0, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

Parametrised AHB-to-APB bridge on the fabric side of the processor/fabric interface. It accepts single transfers on an AHB slave port and replays them as APB3 transfers to NUM_SLV fabric peripherals. Unlike the fixed three-select APB port, it adds per-slave `pready` wait states, `pslverr` mapped to AHB ERROR, decode errors for unmapped slots, and an optional access timeout.

## Interface
Parameters:
- NUM_SLV, 4: number of APB slaves, 1..16.
- PADDR_W, 16: APB address width; `paddr` carries bits [PADDR_W-1:2].
- SEL_LSB, 12: lowest `haddr` bit of the slave index field.
- TIMEOUT_CYC, 255: ACCESS cycles before abort; only used with the timeout macro.

Ports:
- hclk  in  1  clock, rising edge.
- hreset  in  1  synchronous reset, active-high.
- hsel  in  1  AHB slave select.
- haddr  in  32  AHB address.
- htrans  in  2  AHB transfer type.
- hwrite  in  1  AHB write.
- hsize  in  3  AHB size; ignored, all accesses are 32-bit.
- hwdata  in  32  AHB write data.
- hready_in  in  1  bus-level HREADY.
- hready_out  out  1  bridge HREADY.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  32  registered read data.
- paddr  out  PADDR_W-2  APB word address.
- psel  out  NUM_SLV  one-hot select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- pwdata  out  32  APB write data.
- prdata  in  32*NUM_SLV  flattened read data; slave i is at [32i+31:32i].
- pready  in  NUM_SLV  per-slave ready.
- pslverr  in  NUM_SLV  per-slave error.

## Operation
- Transfer accepted when `hsel & htrans[1] & hready_in`. On acceptance the bridge latches `haddr`, `hwrite`, and the slave index `idx = haddr[SEL_LSB +: clog2(NUM_SLV)]`. `haddr` bits above the index field are ignored.
- FSM states:
  - IDLE: `hready_out=1`. An accepted transfer moves to CAPT.
  - CAPT: `hready_out=0`. `hwdata` is latched into `pwdata`. If `idx >= NUM_SLV`, go to ERR1; otherwise go to SETUP.
  - SETUP: `psel[idx]=1`, `penable=0`. Next state is ACCESS.
  - ACCESS: `psel[idx]=1`, `penable=1`. Stay while `pready[idx]=0`.
    - `pready[idx]=1` with `pslverr[idx]=1`: go to ERR1.
    - `pready[idx]=1` with `pslverr[idx]=0`: go to DONE. On a read, `hrdata` is loaded from slave `idx`.
  - DONE: `hready_out=1`, `hresp=OKAY`. An accepted transfer goes to CAPT; otherwise IDLE.
  - ERR1: `hready_out=0`, `hresp=ERROR`.
  - ERR2: `hready_out=1`, `hresp=ERROR`. An accepted transfer goes to CAPT; otherwise IDLE.
- IDLE/BUSY `htrans`, or `hsel=0`, is ignored and produces an OKAY zero-wait response.
- `hrdata` holds its last value on writes and on errors.
- `pwdata`, `paddr`, and `pwrite` stay stable from SETUP through the end of ACCESS.

## Timing
- Reset values: state IDLE, `hready_out=1`, `hresp=00`, `hrdata=0`, `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`.
- Zero-wait APB slave: address phase at cycle N, CAPT at N+1, SETUP at N+2, ACCESS at N+3, DONE at N+4 (`hready_out=1`). That is 3 AHB wait states.
- Each extra low `pready` cycle adds one wait state.
- Decode error: CAPT at N+1, ERR1 at N+2, ERR2 at N+3. No `psel` is asserted.
- `hreset` asserted mid-transfer: all outputs return to reset values at the next edge. The APB transfer is abandoned.
- Back-to-back transfers: an address phase in DONE or ERR2 is accepted with no IDLE cycle in between.
- `pready`/`pslverr` from non-selected slaves are ignored.

## Configuration
- APB_TIMEOUT_EN defined:
  - An 8-to-16-bit counter, sized to TIMEOUT_CYC, clears on SETUP and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYC with `pready[idx]=0`, `psel` and `penable` drop and the FSM goes to ERR1.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

## Structure
- Package `ahb_apb_pkg` holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HRESP_OKAY/ERROR.
  - The FSM state enum.
  - Function `clog2`.
- One sub-module, `apb_slv_mux`: combinational selection of `prdata`, `pready`, and `pslverr` by `idx`, plus one-hot `psel` generation.

## Test plan
- Read from slave 2, zero wait, `prdata2=32'hCAFE_0001` → `psel=4'b0100` for 2 cycles; at N+4 `hready_out=1`, `hrdata=32'hCAFE_0001`, `hresp=00`.
- Write `32'h1234_5678` to slave 0 at `haddr=32'h0000_0010`, with `pready0` low for 3 ACCESS cycles → `paddr=4` and `pwdata=32'h1234_5678` stable; completion at N+7.
- Read with `haddr[13:12]=3` and NUM_SLV=3 → no `psel`; ERR1 then ERR2, with `hresp=01` and `hready_out` 0 then 1.
- Slave 1 returns `pslverr=1` with `pready=1` → two-cycle ERROR; `hrdata` unchanged.
- `hreset` pulsed during ACCESS → next cycle `psel=0`, `penable=0`, `hready_out=1`.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=4, `pready` held low → ERROR response after 4 ACCESS cycles.
